// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32I load/store width codes, opcodes and the
// data-memory access controller state encoding.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RMW_RD,
    RMW_WR,
    WR,
    TURN
  } dmem_state_t;

  // Illegal width code or an address not aligned to the access width.
  function automatic logic req_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = |addr_lo;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Execute-stage request / writeback response bundle of the data-memory
// access controller.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        req_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready, resp_valid, resp_rd, resp_data, req_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready, resp_valid, resp_rd, resp_data, req_err, stall
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic: load extraction with sign/zero extension, and the
// byte/half merge used by read-modify-write stores.
module dmem_lane_unit
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Width code bits [1:0] pick byte vs half regardless of the unsigned flag.
  always_comb begin
    merged = rdata;
    if (funct3[1:0] == 2'b00) begin
      case (offset)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (offset[1]) begin
      merged[31:16] = wdata;
    end else begin
      merged[15:0] = wdata;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: loads, word stores and read-modify-write
// byte/half stores over a shared bidirectional dmem_data bus.
module dmem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave cpu,
  output logic              dmem_wen,
  output logic [31:0]       dmem_addr,
  inout  wire  [31:0]       dmem_data
);

  if (RD_LAT == 0) begin : g_rd_lat_check
    $error("dmem_access_ctrl: RD_LAT must be at least 1");
  end

  localparam int unsigned MAX_CYC = (RD_LAT > TURN_CYC) ? RD_LAT : TURN_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RD_INIT   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TURN_INIT = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  dmem_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;
  logic [31:0]      merged_q;
  logic [4:0]       rd_q;
  logic             fire, accept, err_set, resp_set, merge_set;
  logic [31:0]      load_data, merged;

  assign cpu.req_ready = (state == IDLE) & rst_n;
  assign cpu.stall     = (state != IDLE);
  assign fire          = cpu.req_valid & cpu.req_ready;

  // Drive enable decodes straight from the async-reset state register, so a
  // reset releases the bus immediately.
  assign dmem_wen  = (state == WR) | (state == RMW_WR);
  assign dmem_data = dmem_wen ? ((state == WR) ? wdata_q : merged_q) : 'z;

  dmem_lane_unit u_lane (
    .funct3    (f3_q),
    .offset    (off_q),
    .rdata     (dmem_data),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    err_set   = 1'b0;
    resp_set  = 1'b0;
    merge_set = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          if (req_bad(cpu.req_funct3, cpu.req_addr[1:0])) begin
            err_set = 1'b1;
          end else begin
            accept = 1'b1;
            if (!cpu.req_we) begin
              state_nxt = RD_WAIT;
              cnt_nxt   = RD_INIT;
            end else if (cpu.req_funct3 == F3_W) begin
              state_nxt = WR;
            end else begin
              state_nxt = RMW_RD;
              cnt_nxt   = RD_INIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          resp_set  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RMW_RD: begin
        if (cnt == '0) begin
          merge_set = 1'b1;
          state_nxt = RMW_WR;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WR, RMW_WR: begin
        if (TURN_CYC > 0) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_INIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      TURN: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dmem_addr      <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      wdata_q        <= '0;
      merged_q       <= '0;
      rd_q           <= '0;
      cpu.resp_valid <= 1'b0;
      cpu.resp_rd    <= '0;
      cpu.resp_data  <= '0;
      cpu.req_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cpu.resp_valid <= resp_set;
      cpu.req_err    <= err_set;
      if (accept) begin
        dmem_addr <= {cpu.req_addr[31:2], 2'b00};
        off_q     <= cpu.req_addr[1:0];
        f3_q      <= cpu.req_funct3;
        wdata_q   <= cpu.req_wdata;
        rd_q      <= cpu.req_rd;
      end
      if (resp_set) begin
        cpu.resp_rd   <= rd_q;
        cpu.resp_data <= load_data;
      end
      if (merge_set) merged_q <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: RD_LAT=2 memory model with TURN_CYC=1,
// plus a second instance with TURN_CYC=0 for the back-to-back timing case.
module tb_dmem_access_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl_if bus0 ();
  dmem_access_ctrl_if bus1 ();

  logic        dmem_wen0, dmem_wen1;
  logic [31:0] dmem_addr0, dmem_addr1;
  wire  [31:0] dmem_data0, dmem_data1;

  dmem_access_ctrl #(.RD_LAT(2), .TURN_CYC(1)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (bus0),
    .dmem_wen  (dmem_wen0),
    .dmem_addr (dmem_addr0),
    .dmem_data (dmem_data0)
  );

  dmem_access_ctrl #(.RD_LAT(2), .TURN_CYC(0)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (bus1),
    .dmem_wen  (dmem_wen1),
    .dmem_addr (dmem_addr1),
    .dmem_data (dmem_data1)
  );

  // Memory for dut0: one address register stage gives data valid by the
  // second edge after the address appears.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe0 = '0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          wen_cnt0 = 0;

  always @(posedge clk) begin
    rd_pipe0 <= mem[dmem_addr0[9:2]];
    if (pl_en)          mem[pl_idx] <= pl_val;
    else if (dmem_wen0) mem[dmem_addr0[9:2]] <= dmem_data0;
    if (dmem_wen0) wen_cnt0 <= wen_cnt0 + 1;
  end

  assign dmem_data0 = dmem_wen0 ? 32'bz : rd_pipe0;
  assign dmem_data1 = dmem_wen1 ? 32'bz : 32'h0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic drive0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    bus0.req_valid  = 1'b1;
    bus0.req_we     = we;
    bus0.req_funct3 = f3;
    bus0.req_addr   = addr;
    bus0.req_wdata  = wdata;
    bus0.req_rd     = rd;
  endtask

  task automatic load_test(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] exp);
    drive0(1'b0, f3, addr, 32'h0, rd);
    cyc();
    bus0.req_valid = 1'b0;
    check({tag, "_stall_e0"}, {31'h0, bus0.stall}, 32'd1);
    check({tag, "_addr"}, dmem_addr0, {addr[31:2], 2'b00});
    cyc();
    check({tag, "_stall_e1"}, {31'h0, bus0.stall}, 32'd1);
    check({tag, "_early_resp"}, {31'h0, bus0.resp_valid}, 32'd0);
    cyc();
    check({tag, "_resp_valid"}, {31'h0, bus0.resp_valid}, 32'd1);
    check({tag, "_resp_rd"}, {27'h0, bus0.resp_rd}, {27'h0, rd});
    check({tag, "_resp_data"}, bus0.resp_data, exp);
    check({tag, "_stall_done"}, {31'h0, bus0.stall}, 32'd0);
    cyc();
    check({tag, "_resp_pulse"}, {31'h0, bus0.resp_valid}, 32'd0);
  endtask

  task automatic err_test(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    int wen_before;
    wen_before = wen_cnt0;
    drive0(we, f3, addr, 32'h12345678, 5'd1);
    cyc();
    bus0.req_valid = 1'b0;
    check({tag, "_err"}, {31'h0, bus0.req_err}, 32'd1);
    check({tag, "_ready"}, {31'h0, bus0.req_ready}, 32'd1);
    check({tag, "_stall"}, {31'h0, bus0.stall}, 32'd0);
    cyc();
    check({tag, "_err_pulse"}, {31'h0, bus0.req_err}, 32'd0);
    check({tag, "_no_resp"}, {31'h0, bus0.resp_valid}, 32'd0);
    check({tag, "_no_wen"}, wen_cnt0, wen_before);
  endtask

  initial begin
    int wen_before;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = '0;
    bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_rd = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_rd = '0;

    // Reset state
    cyc();
    check("rst_ready", {31'h0, bus0.req_ready}, 32'd0);
    check("rst_wen", {31'h0, dmem_wen0}, 32'd0);
    check("rst_stall", {31'h0, bus0.stall}, 32'd0);
    check("rst_addr", dmem_addr0, 32'h0);
    check("rst_resp", {31'h0, bus0.resp_valid}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check("ready_after_rst", {31'h0, bus0.req_ready}, 32'd1);

    preload(8'h40, 32'hDEADBEEF);
    preload(8'h80, 32'h0);

    load_test("lw",  F3_W,  32'h100, 5'd5, 32'hDEADBEEF);
    load_test("lb",  F3_B,  32'h103, 5'd6, 32'hFFFFFFDE);
    load_test("lbu", F3_BU, 32'h103, 5'd7, 32'h000000DE);
    load_test("lh",  F3_H,  32'h102, 5'd8, 32'hFFFFDEAD);
    load_test("lhu", F3_HU, 32'h100, 5'd9, 32'h0000BEEF);
    load_test("lb0", F3_B,  32'h100, 5'd10, 32'hFFFFFFEF);

    // SB via read-modify-write
    wen_before = wen_cnt0;
    drive0(1'b1, F3_B, 32'h101, 32'h00000055, 5'd0);
    cyc();
    bus0.req_valid = 1'b0;
    check("sb_rd_wen0", {31'h0, dmem_wen0}, 32'd0);
    cyc();
    check("sb_rd_wen1", {31'h0, dmem_wen0}, 32'd0);
    cyc();
    check("sb_wen", {31'h0, dmem_wen0}, 32'd1);
    check("sb_wr_addr", dmem_addr0, 32'h100);
    check("sb_wr_data", dmem_data0, 32'hDEAD55EF);
    cyc();
    check("sb_turn_wen", {31'h0, dmem_wen0}, 32'd0);
    check("sb_turn_ready", {31'h0, bus0.req_ready}, 32'd0);
    cyc();
    check("sb_ready_back", {31'h0, bus0.req_ready}, 32'd1);
    check("sb_one_pulse", wen_cnt0, wen_before + 1);
    check("sb_mem", mem[8'h40], 32'hDEAD55EF);
    check("sb_no_resp", {31'h0, bus0.resp_valid}, 32'd0);
    load_test("lw_after_sb", F3_W, 32'h100, 5'd11, 32'hDEAD55EF);

    // Dropped requests
    err_test("sw_misaligned", 1'b1, F3_W, 32'h102);
    err_test("f3_3", 1'b0, 3'd3, 32'h100);
    err_test("lh_odd", 1'b0, F3_H, 32'h101);

    // Back-to-back SW then LW with one turnaround cycle
    drive0(1'b1, F3_W, 32'h200, 32'hCAFEF00D, 5'd0);
    cyc();
    drive0(1'b0, F3_W, 32'h200, 32'h0, 5'd12);
    check("b2b_wen", {31'h0, dmem_wen0}, 32'd1);
    check("b2b_wdata", dmem_data0, 32'hCAFEF00D);
    cyc();
    check("b2b_turn_wen", {31'h0, dmem_wen0}, 32'd0);
    check("b2b_turn_ready", {31'h0, bus0.req_ready}, 32'd0);
    cyc();
    check("b2b_idle_ready", {31'h0, bus0.req_ready}, 32'd1);
    cyc();
    bus0.req_valid = 1'b0;
    check("b2b_lw_stall", {31'h0, bus0.stall}, 32'd1);
    cyc();
    cyc();
    check("b2b_lw_resp", {31'h0, bus0.resp_valid}, 32'd1);
    check("b2b_lw_data", bus0.resp_data, 32'hCAFEF00D);
    cyc();

    // TURN_CYC=0: load accepted on the edge right after the write
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_funct3 = F3_W;
    bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0BADF00D; bus1.req_rd = 5'd0;
    cyc();
    bus1.req_we = 1'b0; bus1.req_addr = 32'h10; bus1.req_rd = 5'd3;
    check("t0_wen", {31'h0, dmem_wen1}, 32'd1);
    check("t0_wdata", dmem_data1, 32'h0BADF00D);
    cyc();
    check("t0_ready", {31'h0, bus1.req_ready}, 32'd1);
    check("t0_wen_off", {31'h0, dmem_wen1}, 32'd0);
    cyc();
    bus1.req_valid = 1'b0;
    check("t0_lw_accept", {31'h0, bus1.stall}, 32'd1);
    check("t0_lw_addr", dmem_addr1, 32'h10);
    cyc();
    cyc();
    check("t0_lw_resp", {31'h0, bus1.resp_valid}, 32'd1);
    check("t0_lw_rd", {27'h0, bus1.resp_rd}, 32'd3);
    cyc();

    // Reset in the middle of an SH read phase
    wen_before = wen_cnt0;
    drive0(1'b1, F3_H, 32'h102, 32'h00001234, 5'd0);
    cyc();
    bus0.req_valid = 1'b0;
    check("rmw_rst_busy", {31'h0, bus0.stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmw_rst_wen", {31'h0, dmem_wen0}, 32'd0);
    check("rmw_rst_stall", {31'h0, bus0.stall}, 32'd0);
    check("rmw_rst_ready", {31'h0, bus0.req_ready}, 32'd0);
    check("rmw_rst_addr", dmem_addr0, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    check("rel_wen", {31'h0, dmem_wen0}, 32'd0);
    check("rel_resp", {31'h0, bus0.resp_valid}, 32'd0);
    check("rel_err", {31'h0, bus0.req_err}, 32'd0);
    check("rel_resp_data", bus0.resp_data, 32'h0);
    check("rel_resp_rd", {27'h0, bus0.resp_rd}, 32'd0);
    check("rel_addr", dmem_addr0, 32'h0);
    check("rel_stall", {31'h0, bus0.stall}, 32'd0);
    check("rel_mem", mem[8'h40], 32'hDEAD55EF);
    check("rel_no_write", wen_cnt0, wen_before);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
